alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_pkg.sv | 56 +++++
 rtl/alu_mc_divider.sv | 71 +++++++
 rtl/alu_mc.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding, FSM states and
// the split between single-cycle, multiply and divide opcodes.
// Also used by the testbench to name opcodes.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_SLL   = 4'b0100,
    OP_SRL   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SRA   = 4'b0111,
    OP_SLT   = 4'b1000,
    OP_SLTU  = 4'b1001,
    OP_MUL   = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIV   = 4'b1100,
    OP_DIVU  = 4'b1101,
    OP_REM   = 4'b1110,
    OP_REMU  = 4'b1111
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } alu_state_e;

  typedef enum logic [1:0] {
    CLS_SINGLE,
    CLS_MUL,
    CLS_DIV
  } op_class_e;

  // 1010/1011 are the multiplies, 11xx the divide family, all else is
  // resolved combinationally in one cycle.
  function automatic op_class_e op_class(input logic [3:0] op);
    if (op[3:1] == 3'b101) begin
      return CLS_MUL;
    end else if (op[3:2] == 2'b11) begin
      return CLS_DIV;
    end else begin
      return CLS_SINGLE;
    end
  endfunction

  // Within the divide family bit 0 clear means signed (DIV/REM).
  function automatic logic is_signed_div(input logic [3:0] op);
    return (op[3:2] == 2'b11) && !op[0];
  endfunction

endpackage

// File: rtl/alu_mc_divider.sv
// Unsigned restoring divider core: one quotient bit per cycle.
// Latency: WIDTH cycles after start; last is high during the final iteration.
// Backpressure: none; start restarts the core, abort stops it immediately.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, abort        load operands / cancel iteration
//   dividend, divisor   unsigned operands sampled on start
//   last                final iteration is being performed this cycle
//   quotient, remainder results, valid the cycle after last
module alu_mc_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             last,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;

  // The dividend is shifted out of quo_q MSB-first while quotient bits
  // shift in at the bottom, so one register serves both roles.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  // Bit WIDTH of diff set means the trial subtraction went negative and
  // the partial remainder is restored (kept as shifted).
  assign diff    = shifted - {1'b0, dvs_q};

  assign last      = (cnt_q == CNT_W'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (abort) begin
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: logic/arith/shift/compare in one cycle, iterative MUL and DIV.
// Latency accept->done_o: 1 (single-cycle ops), WIDTH+1 (MUL/MULHU), WIDTH+2 (DIV family).
// Backpressure: ready_o only in IDLE; valid_i while busy is dropped, flush_i aborts.
//
// Ports:
//   clk, rst_n_i                      clock, async active-low reset
//   valid_i / ready_o                 request handshake (accept = valid & ready & !flush)
//   op_i, rdata1_i, rdata2_i, imme_i  opcode, operand A, register / immediate operand B
//   alusrc_i                          1: B = rdata2_i, 0: B = imme_i
//   flush_i                           abort whatever is in flight, no done_o
//   result_o, done_o                  result held until next done_o, one-cycle done pulse
//   zero_o, neg_o, carry_o, ovf_o     flags, held with result_o
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] rdata1_i,
  input  logic [WIDTH-1:0] rdata2_i,
  input  logic [WIDTH-1:0] imme_i,
  input  logic             alusrc_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] result_o,
  output logic             done_o,
  output logic             zero_o,
  output logic             neg_o,
  output logic             carry_o,
  output logic             ovf_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  alu_state_e state;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [SHAMT_W-1:0] shamt;
  op_class_e        cls;
  logic             accept;

  assign op_a   = rdata1_i;
  assign op_b   = alusrc_i ? rdata2_i : imme_i;
  assign shamt  = op_b[SHAMT_W-1:0];
  assign cls    = op_class(op_i);
  assign accept = valid_i & ready_o & ~flush_i;

  // ---------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the live inputs at accept
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;
  logic             sc_ovf;

  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  // a + ~b + 1: the carry out is the inverted borrow.
  assign sub_full = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (op_i)
      OP_AND: sc_res = op_a & op_b;
      OP_OR:  sc_res = op_a | op_b;
      OP_XOR: sc_res = op_a ^ op_b;
      OP_ADD: begin
        sc_res   = add_full[WIDTH-1:0];
        sc_carry = add_full[WIDTH];
        sc_ovf   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                   (add_full[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res   = sub_full[WIDTH-1:0];
        sc_carry = sub_full[WIDTH];
        sc_ovf   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                   (sub_full[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SLL:  sc_res = op_a << shamt;
      OP_SRL:  sc_res = op_a >> shamt;
      OP_SRA:  sc_res = $signed(op_a) >>> shamt;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      default: sc_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Shift-add multiplier: multiplier starts in the low half, product
  // accumulates in the high half and everything shifts right each cycle.
  // ---------------------------------------------------------------------
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0]   mul_mcand;
  logic [CNT_W-1:0]   mul_cnt;
  logic               mul_hi;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_nxt;

  assign mul_sum     = {1'b0, mul_acc[2*WIDTH-1:WIDTH]} +
                       (mul_acc[0] ? {1'b0, mul_mcand} : {(WIDTH+1){1'b0}});
  assign mul_acc_nxt = {mul_sum, mul_acc[WIDTH-1:1]};

  // ---------------------------------------------------------------------
  // Divider: magnitudes go to the unsigned core, signs are re-applied in FIX
  // ---------------------------------------------------------------------
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_start;
  logic             div_last;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic             div_q_neg;
  logic             div_r_neg;
  logic             div_zero;
  logic             div_rem_sel;
  logic [WIDTH-1:0] div_dvd;
  logic [WIDTH-1:0] fix_quo;
  logic [WIDTH-1:0] fix_rem;

  assign a_neg     = is_signed_div(op_i) & op_a[WIDTH-1];
  assign b_neg     = is_signed_div(op_i) & op_b[WIDTH-1];
  // Negating the most-negative value yields itself, which read unsigned is
  // exactly its magnitude, so MIN / -1 falls out as MIN with remainder 0.
  assign a_mag     = a_neg ? -op_a : op_a;
  assign b_mag     = b_neg ? -op_b : op_b;
  assign div_start = accept & (cls == CLS_DIV);

  alu_mc_divider #(
    .WIDTH (WIDTH)
  ) u_divider (
    .clk       (clk),
    .rst_n     (rst_n_i),
    .start     (div_start),
    .abort     (flush_i),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .last      (div_last),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Divide by zero overrides the sign rule: quotient stays all-ones and the
  // remainder is the original dividend.
  assign fix_quo = div_zero  ? '1 : (div_q_neg ? -div_quo : div_quo);
  assign fix_rem = div_zero  ? div_dvd : (div_r_neg ? -div_rem : div_rem);

  // ---------------------------------------------------------------------
  // Result commit: one mux feeds the output registers from whichever
  // datapath finishes this cycle.
  // ---------------------------------------------------------------------
  logic             commit;
  logic [WIDTH-1:0] commit_res;
  logic             commit_carry;
  logic             commit_ovf;

  always_comb begin
    commit       = 1'b0;
    commit_res   = '0;
    commit_carry = 1'b0;
    commit_ovf   = 1'b0;
    case (state)
      ST_IDLE: begin
        commit       = accept & (cls == CLS_SINGLE);
        commit_res   = sc_res;
        commit_carry = sc_carry;
        commit_ovf   = sc_ovf;
      end
      ST_MUL: begin
        commit     = ~flush_i & (mul_cnt == CNT_W'(1));
        commit_res = mul_hi ? mul_acc_nxt[2*WIDTH-1:WIDTH] : mul_acc_nxt[WIDTH-1:0];
      end
      ST_FIX: begin
        commit     = ~flush_i;
        commit_res = div_rem_sel ? fix_rem : fix_quo;
      end
      default: commit = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      ready_o     <= 1'b1;
      done_o      <= 1'b0;
      result_o    <= '0;
      zero_o      <= 1'b0;
      neg_o       <= 1'b0;
      carry_o     <= 1'b0;
      ovf_o       <= 1'b0;
      mul_acc     <= '0;
      mul_mcand   <= '0;
      mul_cnt     <= '0;
      mul_hi      <= 1'b0;
      div_q_neg   <= 1'b0;
      div_r_neg   <= 1'b0;
      div_zero    <= 1'b0;
      div_rem_sel <= 1'b0;
      div_dvd     <= '0;
    end else begin
      done_o <= commit;
      if (commit) begin
        result_o <= commit_res;
        zero_o   <= (commit_res == '0);
        neg_o    <= commit_res[WIDTH-1];
        carry_o  <= commit_carry;
        ovf_o    <= commit_ovf;
      end

      if (flush_i) begin
        state   <= ST_IDLE;
        ready_o <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (valid_i) begin
              ready_o <= 1'b0;
              case (cls)
                CLS_MUL: begin
                  mul_acc   <= {{WIDTH{1'b0}}, op_b};
                  mul_mcand <= op_a;
                  mul_cnt   <= CNT_W'(WIDTH);
                  mul_hi    <= op_i[0];
                  state     <= ST_MUL;
                end
                CLS_DIV: begin
                  div_q_neg   <= a_neg ^ b_neg;
                  div_r_neg   <= a_neg;
                  div_zero    <= (op_b == '0);
                  div_rem_sel <= op_i[1];
                  div_dvd     <= op_a;
                  state       <= ST_DIV;
                end
                default: state <= ST_DONE;
              endcase
            end
          end
          ST_MUL: begin
            mul_acc <= mul_acc_nxt;
            mul_cnt <= mul_cnt - CNT_W'(1);
            if (mul_cnt == CNT_W'(1)) begin
              state <= ST_DONE;
            end
          end
          ST_DIV: begin
            if (div_last) begin
              state <= ST_FIX;
            end
          end
          ST_FIX: state <= ST_DONE;
          ST_DONE: begin
            state   <= ST_IDLE;
            ready_o <= 1'b1;
          end
          default: begin
            state   <= ST_IDLE;
            ready_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
